// File: rtl/repvgg_layer_sched.sv
// repvgg_layer_sched
// Sequences one re-parameterised 3x3 conv layer through the shared conv
// engine. For every output-channel tile it issues a weight load, then a
// feature load / compute / store triple per output row, waiting for the
// engine's completion pulse after each command.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 one-cycle layer start, only honoured when idle
//   cfg_out_ch/cfg_height layer geometry, captured when start is accepted
//   abort                 synchronous abort back to idle, no done pulse
//   busy, done            layer in progress / one-cycle completion pulse
//   cmd_valid, cmd_ready  command handshake towards the conv engine
//   cmd_op                0 WLOAD, 1 FLOAD, 2 COMP, 3 STORE
//   cmd_oc_base/oc_cnt    first channel of the tile and channels in it
//   cmd_row               current output row (0 for WLOAD)
//   eng_done              engine finished the last accepted command
module repvgg_layer_sched #(
    parameter int PE_OC = 16,
    parameter int CH_W  = 10,
    parameter int DIM_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CH_W-1:0]  cfg_out_ch,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [1:0]       cmd_op,
    output logic [CH_W-1:0]  cmd_oc_base,
    output logic [CH_W-1:0]  cmd_oc_cnt,
    output logic [DIM_W-1:0] cmd_row,
    input  logic             eng_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;
    typedef enum logic [1:0] {
        OP_WLOAD = 2'd0,
        OP_FLOAD = 2'd1,
        OP_COMP  = 2'd2,
        OP_STORE = 2'd3
    } op_t;

    // One extra bit so that oc_base + PE_OC never wraps on the last tile.
    localparam logic [CH_W:0] PE_OC_W = (CH_W+1)'(PE_OC);

    state_t           state_q, state_n;
    op_t              op_q, op_n;
    logic [CH_W-1:0]  out_ch_q, out_ch_n;
    logic [DIM_W-1:0] height_q, height_n;
    logic [CH_W:0]    oc_base_q, oc_base_n;
    logic [CH_W-1:0]  oc_cnt_q, oc_cnt_n;
    logic [DIM_W-1:0] row_q, row_n;
    logic [CH_W:0]    next_base;
    logic             last_row;

    // Channels in the tile starting at base: min(PE_OC, total - base).
    // Only evaluated for base < total, so the subtraction cannot underflow.
    function automatic logic [CH_W-1:0] tile_cnt(input logic [CH_W-1:0] total,
                                                 input logic [CH_W:0]   base);
        logic [CH_W:0] rem;
        rem = {1'b0, total} - base;
        if (rem > PE_OC_W)
            return PE_OC_W[CH_W-1:0];
        else
            return rem[CH_W-1:0];
    endfunction

    assign next_base = oc_base_q + PE_OC_W;
    assign last_row  = (row_q == height_q - DIM_W'(1));

    // Payload outputs come straight from their registers.
    assign cmd_op      = op_q;
    assign cmd_oc_base = oc_base_q[CH_W-1:0];
    assign cmd_oc_cnt  = oc_cnt_q;
    assign cmd_row     = row_q;

    // Next-state and sequencing logic. Abort wins over everything; in WAIT the
    // command sequence advances only on eng_done, so completion pulses seen in
    // any other state (including the handshake cycle) have no effect.
    always_comb begin
        state_n   = state_q;
        op_n      = op_q;
        out_ch_n  = out_ch_q;
        height_n  = height_q;
        oc_base_n = oc_base_q;
        oc_cnt_n  = oc_cnt_q;
        row_n     = row_q;
        if (abort) begin
            state_n   = IDLE;
            op_n      = OP_WLOAD;
            oc_base_n = '0;
            oc_cnt_n  = '0;
            row_n     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        out_ch_n  = cfg_out_ch;
                        height_n  = cfg_height;
                        op_n      = OP_WLOAD;
                        oc_base_n = '0;
                        row_n     = '0;
                        oc_cnt_n  = tile_cnt(cfg_out_ch, '0);
                        if (cfg_out_ch == '0 || cfg_height == '0)
                            state_n = FIN;
                        else
                            state_n = ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_ready)
                        state_n = WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        state_n = ISSUE;
                        case (op_q)
                            OP_WLOAD: op_n = OP_FLOAD;
                            OP_FLOAD: op_n = OP_COMP;
                            OP_COMP:  op_n = OP_STORE;
                            OP_STORE: begin
                                if (!last_row) begin
                                    row_n = row_q + DIM_W'(1);
                                    op_n  = OP_FLOAD;
                                end else if (next_base >= {1'b0, out_ch_q}) begin
                                    state_n = FIN;
                                end else begin
                                    oc_base_n = next_base;
                                    oc_cnt_n  = tile_cnt(out_ch_q, next_base);
                                    row_n     = '0;
                                    op_n      = OP_WLOAD;
                                end
                            end
                        endcase
                    end
                end
                FIN: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State, captured configuration, counters and the registered status
    // outputs. busy/done/cmd_valid are decoded from the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= OP_WLOAD;
            out_ch_q  <= '0;
            height_q  <= '0;
            oc_base_q <= '0;
            oc_cnt_q  <= '0;
            row_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_valid <= 1'b0;
        end else begin
            state_q   <= state_n;
            op_q      <= op_n;
            out_ch_q  <= out_ch_n;
            height_q  <= height_n;
            oc_base_q <= oc_base_n;
            oc_cnt_q  <= oc_cnt_n;
            row_q     <= row_n;
            busy      <= (state_n != IDLE);
            done      <= (state_n == FIN);
            cmd_valid <= (state_n == ISSUE);
        end
    end

endmodule

// File: tb/tb_repvgg_layer_sched.sv
// tb_repvgg_layer_sched
// Self-checking bench for repvgg_layer_sched. An engine model answers every
// accepted command with a delayed eng_done; the observed command stream is
// compared against a list built directly from the tile/row arithmetic.
module tb_repvgg_layer_sched;

    localparam int PE_OC  = 16;
    localparam int CH_W   = 10;
    localparam int DIM_W  = 9;
    localparam int BUDGET = 5000;

    typedef struct packed {
        logic [1:0]       op;
        logic [CH_W-1:0]  base;
        logic [CH_W-1:0]  cnt;
        logic [DIM_W-1:0] row;
    } cmd_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CH_W-1:0]  cfg_out_ch = '0;
    logic [DIM_W-1:0] cfg_height = '0;
    logic             abort = 1'b0;
    logic             busy, done, cmd_valid;
    logic             cmd_ready = 1'b0;
    logic [1:0]       cmd_op;
    logic [CH_W-1:0]  cmd_oc_base, cmd_oc_cnt;
    logic [DIM_W-1:0] cmd_row;
    logic             eng_done = 1'b0;

    int errors = 0;
    int checks = 0;

    cmd_t obs[$];
    cmd_t exp_q[$];
    int   n_done, hold_err, busy_err, turn_err, timed_out, done_lat, first_ok, post_ok;

    repvgg_layer_sched #(.PE_OC(PE_OC), .CH_W(CH_W), .DIM_W(DIM_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_out_ch(cfg_out_ch),
        .cfg_height(cfg_height), .abort(abort), .busy(busy), .done(done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_oc_base(cmd_oc_base), .cmd_oc_cnt(cmd_oc_cnt), .cmd_row(cmd_row),
        .eng_done(eng_done)
    );

    always #5 clk = ~clk;

    function automatic cmd_t mk(input int op, input int base, input int cnt, input int row);
        cmd_t c;
        c.op   = 2'(op);
        c.base = CH_W'(base);
        c.cnt  = CH_W'(cnt);
        c.row  = DIM_W'(row);
        return c;
    endfunction

    // Reference command list: per tile a WLOAD, then FLOAD/COMP/STORE per row.
    task automatic build_model(input int oc, input int h);
        exp_q.delete();
        for (int base = 0; base < oc; base += PE_OC) begin
            int cnt;
            cnt = (oc - base < PE_OC) ? (oc - base) : PE_OC;
            exp_q.push_back(mk(0, base, cnt, 0));
            for (int r = 0; r < h; r++) begin
                exp_q.push_back(mk(1, base, cnt, r));
                exp_q.push_back(mk(2, base, cnt, r));
                exp_q.push_back(mk(3, base, cnt, r));
            end
        end
    endtask

    // Runs one layer with the engine model and records what happened.
    task automatic run_layer(input int oc, input int h, input int lat_min, input int lat_max,
                             input int stall_min, input int stall_max,
                             input bit spurious, input bit noise);
        cmd_t cur, prev;
        bit   prev_valid, hs_prev, finished;
        int   countdown, stall_left, last_eng;
        prev_valid = 0; hs_prev = 0; finished = 0;
        countdown = 0; stall_left = 0; last_eng = -10;
        prev = '0;
        obs.delete();
        n_done = 0; hold_err = 0; busy_err = 0; turn_err = 0;
        timed_out = 1; done_lat = -1; first_ok = 0; post_ok = 0;
        cfg_out_ch = CH_W'(oc);
        cfg_height = DIM_W'(h);
        start = 1; abort = 0; cmd_ready = 0; eng_done = 0;
        @(posedge clk); #1;
        for (int cyc = 1; cyc < BUDGET; cyc++) begin
            cur.op = cmd_op; cur.base = cmd_oc_base; cur.cnt = cmd_oc_cnt; cur.row = cmd_row;
            start = 0; cmd_ready = 0; eng_done = 0;
            if (cyc == 1) first_ok = (busy && cmd_valid && !done) ? 1 : 0;
            if (finished) begin
                post_ok = (!busy && !done && !cmd_valid) ? 1 : 0;
                timed_out = 0;
                break;
            end
            if (done) begin
                n_done++;
                finished = 1;
                done_lat = cyc - last_eng;
            end
            if (!busy) busy_err++;
            if (hs_prev && cmd_valid) turn_err++;
            hs_prev = 0;
            if (cmd_valid) begin
                if (prev_valid) begin
                    if (cur !== prev) hold_err++;
                end else begin
                    if (obs.size() > 0 && last_eng != cyc - 1) turn_err++;
                    stall_left = $urandom_range(stall_max, stall_min);
                end
                if (stall_left > 0) begin
                    stall_left--;
                    if (spurious) eng_done = 1;
                end else begin
                    cmd_ready = 1;
                    obs.push_back(cur);
                    hs_prev = 1;
                    countdown = $urandom_range(lat_max, lat_min);
                    if (spurious) eng_done = 1;
                end
                prev = cur;
                prev_valid = !cmd_ready;
            end else begin
                prev_valid = 0;
                if (countdown > 0) begin
                    countdown--;
                    if (countdown == 0) begin
                        eng_done = 1;
                        last_eng = cyc;
                    end
                end
            end
            if (noise && busy && !done && (cyc % 5 == 2)) begin
                start = 1;
                cfg_out_ch = CH_W'($urandom);
                cfg_height = DIM_W'($urandom);
            end
            @(posedge clk); #1;
        end
        start = 0; cmd_ready = 0; eng_done = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, cmd_valid, cmd_op, cmd_oc_base, cmd_oc_cnt, cmd_row} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b valid=%b op=%0d base=%0d cnt=%0d row=%0d, expected all 0",
                     busy, done, cmd_valid, cmd_op, cmd_oc_base, cmd_oc_cnt, cmd_row);
        end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got busy=%b valid=%b, expected 0 0", busy, cmd_valid);
        end
    endtask

    task automatic test_basic;
        int ntile;
        run_layer(32, 2, 3, 3, 0, 0, 0, 0);
        build_model(32, 2);
        ntile = (32 + PE_OC - 1) / PE_OC;
        checks++;
        if (obs.size() !== ntile * (1 + 3 * 2)) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d commands, expected %0d", obs.size(), ntile * 7);
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL basic_cmd[%0d]: got op=%0d base=%0d cnt=%0d row=%0d, expected op=%0d base=%0d cnt=%0d row=%0d",
                         i, obs[i].op, obs[i].base, obs[i].cnt, obs[i].row,
                         exp_q[i].op, exp_q[i].base, exp_q[i].cnt, exp_q[i].row);
            end
        end
        checks++;
        if (first_ok !== 1) begin
            errors++;
            $display("[TB] FAIL basic_first_cycle: got %0d, expected busy and cmd_valid in cycle 1 (1)", first_ok);
        end
        checks++;
        if (n_done !== 1 || done_lat !== 1 || post_ok !== 1 || timed_out !== 0) begin
            errors++;
            $display("[TB] FAIL basic_done: got pulses=%0d latency=%0d post_idle=%0d timeout=%0d, expected 1 1 1 0",
                     n_done, done_lat, post_ok, timed_out);
        end
        checks++;
        if (busy_err !== 0 || turn_err !== 0) begin
            errors++;
            $display("[TB] FAIL basic_timing: got busy_drops=%0d turnaround_errs=%0d, expected 0 0", busy_err, turn_err);
        end
    endtask

    task automatic test_partial_tile;
        run_layer(20, 1, 1, 2, 0, 1, 0, 0);
        build_model(20, 1);
        checks++;
        if (obs.size() !== 8) begin
            errors++;
            $display("[TB] FAIL partial_count: got %0d commands, expected 8", obs.size());
        end
        checks++;
        if (obs.size() > 4 && obs[4] !== mk(0, 16, 4, 0)) begin
            errors++;
            $display("[TB] FAIL partial_wload2: got op=%0d base=%0d cnt=%0d, expected op=0 base=16 cnt=4",
                     obs[4].op, obs[4].base, obs[4].cnt);
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL partial_cmd[%0d]: got op=%0d base=%0d cnt=%0d row=%0d, expected op=%0d base=%0d cnt=%0d row=%0d",
                         i, obs[i].op, obs[i].base, obs[i].cnt, obs[i].row,
                         exp_q[i].op, exp_q[i].base, exp_q[i].cnt, exp_q[i].row);
            end
        end
    endtask

    task automatic test_zero_size;
        int ocs[2];
        int hs[2];
        ocs[0] = 0; hs[0] = 3;
        ocs[1] = 5; hs[1] = 0;
        for (int k = 0; k < 2; k++) begin
            cfg_out_ch = CH_W'(ocs[k]);
            cfg_height = DIM_W'(hs[k]);
            start = 1;
            @(posedge clk); #1;
            start = 0;
            checks++;
            if (busy !== 1'b1 || done !== 1'b1 || cmd_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL zero_cycle1[%0d]: got busy=%b done=%b valid=%b, expected 1 1 0", k, busy, done, cmd_valid);
            end
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || cmd_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL zero_cycle2[%0d]: got busy=%b done=%b valid=%b, expected 0 0 0", k, busy, done, cmd_valid);
            end
        end
    endtask

    task automatic test_stall;
        run_layer(16, 1, 2, 2, 5, 5, 1, 0);
        build_model(16, 1);
        checks++;
        if (hold_err !== 0 || obs.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL stall_hold: got unstable=%0d commands=%0d, expected 0 %0d", hold_err, obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL stall_cmd[%0d]: got op=%0d row=%0d, expected op=%0d row=%0d",
                         i, obs[i].op, obs[i].row, exp_q[i].op, exp_q[i].row);
            end
        end
        checks++;
        if (n_done !== 1 || turn_err !== 0) begin
            errors++;
            $display("[TB] FAIL stall_done: got pulses=%0d turnaround_errs=%0d, expected 1 0", n_done, turn_err);
        end
    endtask

    task automatic test_abort;
        int  hs, cd, bad;
        bit  fired;
        hs = 0; cd = 0; bad = 0; fired = 0;
        cfg_out_ch = 10'd32; cfg_height = 9'd2; start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int cyc = 0; cyc < 200 && !fired; cyc++) begin
            cmd_ready = 0; eng_done = 0;
            if (cmd_valid) begin
                cmd_ready = 1; hs++; cd = 2;
            end else if (hs == 5) begin
                abort = 1; fired = 1;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) eng_done = 1;
            end
            @(posedge clk); #1;
        end
        abort = 0; cmd_ready = 0; eng_done = 0;
        checks++;
        if (fired !== 1'b1 || busy !== 1'b0 || cmd_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_wait: got reached=%b busy=%b valid=%b done=%b, expected 1 0 0 0", fired, busy, cmd_valid, done);
        end
        for (int i = 0; i < 5; i++) begin
            if (busy || done || cmd_valid) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL abort_quiet: got %0d active cycles, expected 0", bad);
        end
        run_layer(20, 1, 1, 2, 0, 0, 0, 0);
        checks++;
        if (obs.size() !== 8 || (obs.size() > 0 && obs[0] !== mk(0, 0, 16, 0))) begin
            errors++;
            $display("[TB] FAIL abort_restart: got commands=%0d first_op=%0d first_base=%0d, expected 8 0 0",
                     obs.size(), obs.size() > 0 ? obs[0].op : 2'd0, obs.size() > 0 ? obs[0].base : 10'd0);
        end
    endtask

    task automatic test_abort_issue;
        cfg_out_ch = 10'd16; cfg_height = 9'd1; start = 1;
        @(posedge clk); #1;
        start = 0;
        checks++;
        if (cmd_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_issue_pre: got valid=%b, expected 1", cmd_valid);
        end
        abort = 1; cmd_ready = 0;
        @(posedge clk); #1;
        abort = 0;
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_issue: got valid=%b busy=%b done=%b, expected 0 0 0", cmd_valid, busy, done);
        end
    endtask

    task automatic test_ignore_start;
        run_layer(48, 2, 1, 3, 0, 1, 0, 1);
        build_model(48, 2);
        checks++;
        if (obs.size() !== exp_q.size() || n_done !== 1) begin
            errors++;
            $display("[TB] FAIL ignore_start_count: got commands=%0d pulses=%0d, expected %0d 1", obs.size(), n_done, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL ignore_start_cmd[%0d]: got op=%0d base=%0d cnt=%0d row=%0d, expected op=%0d base=%0d cnt=%0d row=%0d",
                         i, obs[i].op, obs[i].base, obs[i].cnt, obs[i].row,
                         exp_q[i].op, exp_q[i].base, exp_q[i].cnt, exp_q[i].row);
            end
        end
    endtask

    task automatic test_back_to_back;
        run_layer(16, 1, 1, 1, 0, 0, 0, 0);
        run_layer(40, 1, 1, 2, 0, 0, 0, 0);
        build_model(40, 1);
        checks++;
        if (first_ok !== 1 || obs.size() !== exp_q.size() || n_done !== 1) begin
            errors++;
            $display("[TB] FAIL back_to_back: got first_cycle=%0d commands=%0d pulses=%0d, expected 1 %0d 1",
                     first_ok, obs.size(), n_done, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL b2b_cmd[%0d]: got op=%0d base=%0d cnt=%0d row=%0d, expected op=%0d base=%0d cnt=%0d row=%0d",
                         i, obs[i].op, obs[i].base, obs[i].cnt, obs[i].row,
                         exp_q[i].op, exp_q[i].base, exp_q[i].cnt, exp_q[i].row);
            end
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 6; it++) begin
            int oc, h;
            oc = $urandom_range(70, 1);
            h  = $urandom_range(4, 1);
            run_layer(oc, h, 1, 4, 0, 2, 1'($urandom), 1);
            build_model(oc, h);
            checks++;
            if (obs.size() !== exp_q.size() || n_done !== 1 || done_lat !== 1 || timed_out !== 0) begin
                errors++;
                $display("[TB] FAIL random[%0d] oc=%0d h=%0d: got commands=%0d pulses=%0d latency=%0d timeout=%0d, expected %0d 1 1 0",
                         it, oc, h, obs.size(), n_done, done_lat, timed_out, exp_q.size());
            end
            checks++;
            if (hold_err !== 0 || busy_err !== 0 || turn_err !== 0 || post_ok !== 1) begin
                errors++;
                $display("[TB] FAIL random_protocol[%0d]: got unstable=%0d busy_drops=%0d turnaround=%0d post_idle=%0d, expected 0 0 0 1",
                         it, hold_err, busy_err, turn_err, post_ok);
            end
            for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++;
                    $display("[TB] FAIL random_cmd[%0d][%0d]: got op=%0d base=%0d cnt=%0d row=%0d, expected op=%0d base=%0d cnt=%0d row=%0d",
                             it, i, obs[i].op, obs[i].base, obs[i].cnt, obs[i].row,
                             exp_q[i].op, exp_q[i].base, exp_q[i].cnt, exp_q[i].row);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        cfg_out_ch = 10'd32; cfg_height = 9'd2; start = 1;
        @(posedge clk); #1;
        start = 0; cmd_ready = 0;
        checks++;
        if (busy !== 1'b1 || cmd_valid !== 1'b1 || cmd_oc_cnt !== 10'd16) begin
            errors++;
            $display("[TB] FAIL async_pre: got busy=%b valid=%b cnt=%0d, expected 1 1 16", busy, cmd_valid, cmd_oc_cnt);
        end
        #3;
        rst_n = 0;
        #1;
        checks++;
        if ({busy, done, cmd_valid, cmd_op, cmd_oc_base, cmd_oc_cnt, cmd_row} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got busy=%b done=%b valid=%b op=%0d base=%0d cnt=%0d row=%0d, expected all 0",
                     busy, done, cmd_valid, cmd_op, cmd_oc_base, cmd_oc_cnt, cmd_row);
        end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_release: got busy=%b valid=%b, expected 0 0", busy, cmd_valid);
        end
    endtask

    initial begin
        $display("[TB] repvgg_layer_sched bench starting");
        test_reset();
        test_basic();
        test_partial_tile();
        test_zero_size();
        test_stall();
        test_abort();
        test_abort_issue();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/repvgg_layer_sched.md
# repvgg_layer_sched

Layer scheduler for the RepVGG accelerator. It sequences one re-parameterised 3x3 conv layer through the shared conv engine. It walks output-channel tiles and feature-map rows, and issues weight-load, feature-load, compute and store commands over a valid/ready command port, waiting for the engine's completion pulse after each one. It sits between the host configuration registers and the conv/buffer datapath inside the accelerator top.

## Interface
- PE_OC, 16: output channels processed per tile (PE array width); power of two, ≥2
- CH_W, 10: width of channel counts
- DIM_W, 9: width of row counts
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle layer start; sampled only in IDLE
- cfg_out_ch  in  CH_W  output channels of layer; captured on accepted start
- cfg_height  in  DIM_W  output rows of layer; captured on accepted start
- abort  in  1  synchronous abort; highest priority after reset
- busy  out  1  high from cycle after accepted start until done/abort
- done  out  1  one-cycle pulse at layer completion
- cmd_valid  out  1  command valid
- cmd_ready  in  1  engine accepts command
- cmd_op  out  2  0 WLOAD, 1 FLOAD, 2 COMP, 3 STORE
- cmd_oc_base  out  CH_W  first output channel of current tile
- cmd_oc_cnt  out  CH_W  channels in tile = min(PE_OC, out_ch − oc_base)
- cmd_row  out  DIM_W  current row (0 for WLOAD)
- eng_done  in  1  one-cycle pulse: last accepted command finished

## Operation
- States: IDLE, ISSUE, WAIT, FIN.
- IDLE: start=1 captures cfg and clears oc_base=0, row=0, op=WLOAD. If cfg_out_ch==0 or cfg_height==0, go to FIN. Otherwise go to ISSUE.
- ISSUE: cmd_valid=1 with op/oc_base/oc_cnt/row. cmd_valid and the payload are held stable until cmd_valid&cmd_ready. On the handshake, go to WAIT.
- WAIT: cmd_valid=0. On eng_done, advance the sequence and return to ISSUE, or go to FIN after the last STORE.
- Sequence per tile: WLOAD, then for row = 0..height−1 the commands FLOAD, COMP, STORE. After the last row's STORE: oc_base += PE_OC and row=0. If oc_base ≥ out_ch, the layer is finished; otherwise issue WLOAD for the next tile.
- Total commands = ntile·(1+3·height), where ntile = ceil(out_ch/PE_OC).
- oc_base arithmetic uses CH_W+1 bits internally so oc_base+PE_OC cannot wrap. cmd_oc_cnt is computed from the captured out_ch.
- FIN: done=1 for one cycle, then return to IDLE.
- eng_done outside WAIT is ignored, including in the cycle of the handshake itself.
- start outside IDLE is ignored. Cfg changes after capture have no effect.
- abort in any state: next state IDLE; cmd_valid drops at the next edge (this overrides hold-until-ready); busy=0; no done pulse; counters cleared.
- Reset: all outputs 0 (busy, done, cmd_valid, cmd_op, cmd_oc_base, cmd_oc_cnt, cmd_row); state IDLE.

## Timing
- All outputs are registered.
- start sampled at edge 0. busy=1 and cmd_valid=1 (WLOAD) are visible from cycle 1.
- Handshake at edge N: cmd_valid=0 from cycle N+1.
- eng_done at edge M in WAIT: next command valid in cycle M+1 (one-cycle turnaround).
- The final STORE's eng_done at edge M gives done=1 in cycle M+1 and busy=0 in cycle M+2.
- Zero-size layer: start at edge 0 gives busy=1 in cycle 1 with done=1 in the same cycle, then busy=0 in cycle 2. No command is issued.
- Back-to-back layers: start is accepted in the first IDLE cycle after done.

## Test plan
- PE_OC=16, out_ch=32, height=2, engine returns eng_done 3 cycles after each handshake -> 14 commands in order WLOAD(0,16), FLOAD0, COMP0, STORE0, FLOAD1, COMP1, STORE1, WLOAD(16,16), …; exactly one done pulse; busy high throughout.
- out_ch=20, height=1 -> second tile WLOAD has oc_base=16, oc_cnt=4; 8 commands total.
- out_ch=0 or height=0 -> done in cycle 1, cmd_valid never asserts.
- cmd_ready held low for 5 cycles during ISSUE -> cmd_valid and payload stable all 5 cycles; exactly one handshake. A spurious eng_done during ISSUE is ignored.
- abort during WAIT of the 5th command -> cmd_valid=0 and busy=0 next cycle, no done. A new start then begins again at WLOAD(0,…).
- start pulses while busy with different cfg -> ignored; the sequence matches the originally captured cfg. Async reset mid-layer -> all outputs 0 immediately.
